// File: rtl/ps16_access_splitter_if.sv
// Pi-access / bus-cycle signal bundle for ps16_access_splitter.
// slave: the splitter's view; master: the Pi side plus the bus-cycle engine.
interface ps16_access_splitter_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic        req_read;
    logic [2:0]  req_fc;
    logic [31:0] req_wdata;

    logic        bus_start;
    logic [22:0] bus_addr;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_read;
    logic [2:0]  bus_fc;
    logic [15:0] bus_wdata;
    logic        bus_done;
    logic        bus_berr;
    logic [15:0] bus_rdata;
    logic        bus_abort;

    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [31:0] resp_rdata;

    modport slave (
        input  req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
        input  bus_done, bus_berr, bus_rdata,
        output req_ready,
        output bus_start, bus_addr, bus_uds, bus_lds, bus_read, bus_fc, bus_wdata, bus_abort,
        output resp_valid, resp_status, resp_rdata
    );

    modport master (
        output req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
        output bus_done, bus_berr, bus_rdata,
        input  req_ready,
        input  bus_start, bus_addr, bus_uds, bus_lds, bus_read, bus_fc, bus_wdata, bus_abort,
        input  resp_valid, resp_status, resp_rdata
    );
endinterface

// File: rtl/ps16_access_splitter.sv
// Splits one Pi byte/word/long access into one or two 16-bit 68000 bus cycles,
// assembles read data, and reports a single completion status with a per-cycle timeout.
module ps16_access_splitter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 13
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    ps16_access_splitter_if.slave  acc
);

    typedef enum logic [2:0] {StIdle, StIssue1, StWait1, StIssue2, StWait2, StResp} state_e;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatBusErr  = 2'b01;
    localparam logic [1:0] StatAddrErr = 2'b10;
    localparam logic [1:0] StatTimeout = 2'b11;

    state_e            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  tmo_cnt_q;

    logic              is_long_q, is_byte_q, odd_q;
    logic [22:0]       addr_q;
    logic              uds_q, lds_q, read_q;
    logic [2:0]        fc_q;
    logic [15:0]       wdata_q, wdata_lo_q;

    logic accept, misaligned, in_wait, tmo_hit;

    assign accept     = (state_q == StIdle) && acc.req_valid;
    assign misaligned = (acc.req_size != 2'd0) && acc.req_addr[0];
    assign in_wait    = (state_q == StWait1) || (state_q == StWait2);
    // bus_done in the firing cycle takes priority over the timeout
    assign tmo_hit    = in_wait && (TIMEOUT_CYCLES != 0) && !acc.bus_done &&
                        (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, completion status and pulse outputs
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (misaligned) begin
                        state_d  = StResp;
                        status_d = StatAddrErr;
                    end else begin
                        state_d = StIssue1;
                    end
                end
            end
            StIssue1: state_d = StWait1;
            StIssue2: state_d = StWait2;
            StWait1, StWait2: begin
                if (acc.bus_done) begin
                    if (acc.bus_berr) begin
                        state_d  = StResp;
                        status_d = StatBusErr;
                    end else if ((state_q == StWait1) && is_long_q) begin
                        state_d = StIssue2;
                    end else begin
                        state_d  = StResp;
                        status_d = StatOk;
                    end
                end else if (tmo_hit) begin
                    state_d  = StResp;
                    status_d = StatTimeout;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign acc.req_ready   = (state_q == StIdle);
    assign acc.bus_start   = (state_q == StIssue1) || (state_q == StIssue2);
    assign acc.bus_abort   = tmo_hit;
    assign acc.resp_valid  = (state_q == StResp);
    assign acc.resp_status = status_q;
    assign acc.resp_rdata  = rdata_q;
    assign acc.bus_addr    = addr_q;
    assign acc.bus_uds     = uds_q;
    assign acc.bus_lds     = lds_q;
    assign acc.bus_read    = read_q;
    assign acc.bus_fc      = fc_q;
    assign acc.bus_wdata   = wdata_q;

    // State and status registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            status_q <= StatOk;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Bus-cycle fields: loaded at accept, advanced to the second half of a long
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            is_long_q  <= 1'b0;
            is_byte_q  <= 1'b0;
            odd_q      <= 1'b0;
            addr_q     <= '0;
            uds_q      <= 1'b0;
            lds_q      <= 1'b0;
            read_q     <= 1'b0;
            fc_q       <= '0;
            wdata_q    <= '0;
            wdata_lo_q <= '0;
        end else if (accept) begin
            is_long_q  <= (acc.req_size == 2'd2);
            is_byte_q  <= (acc.req_size == 2'd0);
            odd_q      <= acc.req_addr[0];
            addr_q     <= acc.req_addr[23:1];
            uds_q      <= (acc.req_size != 2'd0) || !acc.req_addr[0];
            lds_q      <= (acc.req_size != 2'd0) || acc.req_addr[0];
            read_q     <= acc.req_read;
            fc_q       <= acc.req_fc;
            wdata_lo_q <= acc.req_wdata[15:0];
            if (acc.req_size == 2'd2) begin
                wdata_q <= acc.req_wdata[31:16];
            end else if (acc.req_size == 2'd0) begin
                wdata_q <= {acc.req_wdata[7:0], acc.req_wdata[7:0]};
            end else begin
                wdata_q <= acc.req_wdata[15:0];
            end
        end else if ((state_q == StWait1) && (state_d == StIssue2)) begin
            // 23-bit word address wraps, giving addr+2 modulo 2^24
            addr_q  <= addr_q + 23'd1;
            wdata_q <= wdata_lo_q;
        end
    end

    // Read-data assembly; a bus error still captures the half that terminated
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdata_q <= '0;
        end else if (in_wait && acc.bus_done && read_q) begin
            if (is_byte_q) begin
                rdata_q <= {24'd0, odd_q ? acc.bus_rdata[7:0] : acc.bus_rdata[15:8]};
            end else if (is_long_q) begin
                if (state_q == StWait1) begin
                    rdata_q[31:16] <= acc.bus_rdata;
                end else begin
                    rdata_q[15:0] <= acc.bus_rdata;
                end
            end else begin
                rdata_q <= {16'd0, acc.bus_rdata};
            end
        end
    end

    // Per-cycle timeout counter: cleared while launching, counts while waiting
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_q <= '0;
        end else if (acc.bus_start) begin
            tmo_cnt_q <= '0;
        end else if (in_wait) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ps16_access_splitter.sv
// Directed self-checking bench for ps16_access_splitter (TIMEOUT_CYCLES=16).
module tb_ps16_access_splitter;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b1;
    always #5 sys_clk = ~sys_clk;

    ps16_access_splitter_if sif ();

    ps16_access_splitter #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (13)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .acc      (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Event monitor sampling on the falling edge
    int nstart = 0, nresp = 0, nabort = 0;
    int acc_cyc = 0, done_cyc = 0, resp_cyc = 0, abort_cyc = 0;
    logic [22:0] st_addr [32];
    logic        st_uds  [32];
    logic        st_lds  [32];
    logic        st_rd   [32];
    logic [2:0]  st_fc   [32];
    logic [15:0] st_wd   [32];
    int          st_cyc  [32];
    logic [1:0]  r_status;
    logic [31:0] r_rdata;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (sif.req_valid && sif.req_ready) acc_cyc = cyc;
        if (sif.bus_done) done_cyc = cyc;
        if (sif.bus_start) begin
            st_addr[nstart % 32] = sif.bus_addr;
            st_uds[nstart % 32]  = sif.bus_uds;
            st_lds[nstart % 32]  = sif.bus_lds;
            st_rd[nstart % 32]   = sif.bus_read;
            st_fc[nstart % 32]   = sif.bus_fc;
            st_wd[nstart % 32]   = sif.bus_wdata;
            st_cyc[nstart % 32]  = cyc;
            nstart++;
        end
        if (sif.resp_valid) begin
            resp_cyc = cyc;
            r_status = sif.resp_status;
            r_rdata  = sif.resp_rdata;
            nresp++;
        end
        if (sif.bus_abort) begin
            abort_cyc = cyc;
            nabort++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [23:0] a, input logic [1:0] sz, input logic rd,
                         input logic [2:0] fc, input logic [31:0] wd);
        @(posedge sys_clk); #1;
        sif.req_addr  = a;
        sif.req_size  = sz;
        sif.req_read  = rd;
        sif.req_fc    = fc;
        sif.req_wdata = wd;
        sif.req_valid = 1'b1;
        @(posedge sys_clk); #1;
        sif.req_valid = 1'b0;
    endtask

    task automatic wait_start(input int target);
        for (int i = 0; i < 300 && nstart < target; i++) begin
            @(negedge sys_clk); #1;
        end
        chk("bus_start_seen", 32'(nstart >= target), 32'd1);
    endtask

    // Terminate the bus cycle dly cycles after its bus_start
    task automatic reply(input int target, input int dly, input logic [15:0] data,
                         input logic berr);
        wait_start(target);
        repeat (dly) @(posedge sys_clk);
        #1;
        sif.bus_done  = 1'b1;
        sif.bus_berr  = berr;
        sif.bus_rdata = data;
        @(posedge sys_clk); #1;
        sif.bus_done  = 1'b0;
        sif.bus_berr  = 1'b0;
        sif.bus_rdata = 16'h0000;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 300 && nresp < target; i++) begin
            @(negedge sys_clk); #1;
        end
        chk("resp_seen", 32'(nresp >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int s0, r0, a0, d1;

    initial begin
        sif.req_valid = 1'b0;
        sif.req_addr  = '0;
        sif.req_size  = '0;
        sif.req_read  = 1'b0;
        sif.req_fc    = '0;
        sif.req_wdata = '0;
        sif.bus_done  = 1'b0;
        sif.bus_berr  = 1'b0;
        sif.bus_rdata = '0;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Reset state
        chk("rst_req_ready", 32'(sif.req_ready), 32'd1);
        chk("rst_bus_start", 32'(sif.bus_start), 32'd0);
        chk("rst_resp_valid", 32'(sif.resp_valid), 32'd0);
        chk("rst_bus_abort", 32'(sif.bus_abort), 32'd0);
        chk("rst_resp_rdata", sif.resp_rdata, 32'h0);
        chk("rst_resp_status", 32'(sif.resp_status), 32'd0);
        chk("rst_bus_addr", 32'(sif.bus_addr), 32'h0);
        chk("rst_lanes", 32'({sif.bus_uds, sif.bus_lds}), 32'd0);

        // Word read, 10-cycle bus response
        s0 = nstart; r0 = nresp;
        issue(24'hDFF01C, 2'd1, 1'b1, 3'd5, 32'h0);
        reply(s0 + 1, 10, 16'hA55A, 1'b0);
        wait_resp(r0 + 1);
        repeat (3) @(posedge sys_clk);
        chk("wr_nstart", 32'(nstart - s0), 32'd1);
        chk("wr_start_lat", 32'(st_cyc[s0 % 32] - acc_cyc), 32'd1);
        chk("wr_addr", 32'(st_addr[s0 % 32]), 32'h6FF80E);
        chk("wr_lanes", 32'({st_uds[s0 % 32], st_lds[s0 % 32]}), 32'b11);
        chk("wr_read", 32'(st_rd[s0 % 32]), 32'd1);
        chk("wr_fc", 32'(st_fc[s0 % 32]), 32'd5);
        chk("wr_resp_lat", 32'(resp_cyc - done_cyc), 32'd1);
        chk("wr_status", 32'(r_status), 32'd0);
        chk("wr_rdata", r_rdata, 32'h0000A55A);
        chk("wr_nresp", 32'(nresp - r0), 32'd1);

        // Long write split into two halves
        s0 = nstart; r0 = nresp;
        issue(24'h000100, 2'd2, 1'b0, 3'd1, 32'h12345678);
        reply(s0 + 1, 3, 16'h0, 1'b0);
        d1 = done_cyc;
        reply(s0 + 2, 2, 16'h0, 1'b0);
        wait_resp(r0 + 1);
        repeat (3) @(posedge sys_clk);
        chk("lw_nstart", 32'(nstart - s0), 32'd2);
        chk("lw_addr1", 32'(st_addr[s0 % 32]), 32'h000080);
        chk("lw_wd1", 32'(st_wd[s0 % 32]), 32'h1234);
        chk("lw_addr2", 32'(st_addr[(s0 + 1) % 32]), 32'h000081);
        chk("lw_wd2", 32'(st_wd[(s0 + 1) % 32]), 32'h5678);
        chk("lw_read", 32'(st_rd[s0 % 32]), 32'd0);
        chk("lw_start2_lat", 32'(st_cyc[(s0 + 1) % 32] - d1), 32'd1);
        chk("lw_nresp", 32'(nresp - r0), 32'd1);
        chk("lw_status", 32'(r_status), 32'd0);
        chk("lw_rdata_kept", r_rdata, 32'h0000A55A);

        // Byte write to odd address
        s0 = nstart; r0 = nresp;
        issue(24'hBFE001, 2'd0, 1'b0, 3'd1, 32'h000000C3);
        reply(s0 + 1, 2, 16'hFFFF, 1'b0);
        wait_resp(r0 + 1);
        chk("bw_addr", 32'(st_addr[s0 % 32]), 32'h5FF000);
        chk("bw_lanes", 32'({st_uds[s0 % 32], st_lds[s0 % 32]}), 32'b01);
        chk("bw_wdata", 32'(st_wd[s0 % 32]), 32'hC3C3);
        chk("bw_rdata_kept", r_rdata, 32'h0000A55A);

        // Byte read at even address
        s0 = nstart; r0 = nresp;
        issue(24'hBFE000, 2'd0, 1'b1, 3'd1, 32'h0);
        reply(s0 + 1, 4, 16'h7F00, 1'b0);
        wait_resp(r0 + 1);
        chk("br_lanes", 32'({st_uds[s0 % 32], st_lds[s0 % 32]}), 32'b10);
        chk("br_rdata", r_rdata, 32'h0000007F);

        // Misaligned long: address error, no bus cycle
        s0 = nstart; r0 = nresp;
        issue(24'h000003, 2'd2, 1'b1, 3'd1, 32'h0);
        wait_resp(r0 + 1);
        repeat (3) @(posedge sys_clk);
        chk("ae_nstart", 32'(nstart - s0), 32'd0);
        chk("ae_resp_lat", 32'(resp_cyc - acc_cyc), 32'd1);
        chk("ae_status", 32'(r_status), 32'd2);

        // Long read wrapping past the top of the address space
        s0 = nstart; r0 = nresp;
        issue(24'hFFFFFE, 2'd2, 1'b1, 3'd1, 32'h0);
        reply(s0 + 1, 2, 16'h1111, 1'b0);
        reply(s0 + 2, 3, 16'h2222, 1'b0);
        wait_resp(r0 + 1);
        chk("wrap_addr1", 32'(st_addr[s0 % 32]), 32'h7FFFFF);
        chk("wrap_addr2", 32'(st_addr[(s0 + 1) % 32]), 32'h000000);
        chk("wrap_rdata", r_rdata, 32'h11112222);
        chk("wrap_status", 32'(r_status), 32'd0);

        // Long read, bus error on first half
        s0 = nstart; r0 = nresp;
        issue(24'h000200, 2'd2, 1'b1, 3'd1, 32'h0);
        reply(s0 + 1, 4, 16'hBEEF, 1'b1);
        wait_resp(r0 + 1);
        repeat (5) @(posedge sys_clk);
        chk("be_nstart", 32'(nstart - s0), 32'd1);
        chk("be_status", 32'(r_status), 32'd1);
        chk("be_rdata", r_rdata, 32'hBEEF2222);

        // Stray bus_done while idle is ignored
        r0 = nresp;
        @(posedge sys_clk); #1;
        sif.bus_done = 1'b1; sif.bus_rdata = 16'h5555;
        @(posedge sys_clk); #1;
        sif.bus_done = 1'b0; sif.bus_rdata = 16'h0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("idle_done_nresp", 32'(nresp - r0), 32'd0);
        chk("idle_done_rdata", sif.resp_rdata, 32'hBEEF2222);

        // Timeout: no bus_done at all
        s0 = nstart; r0 = nresp; a0 = nabort;
        issue(24'h000400, 2'd1, 1'b1, 3'd1, 32'h0);
        wait_resp(r0 + 1);
        chk("to_nabort", 32'(nabort - a0), 32'd1);
        chk("to_abort_lat", 32'(abort_cyc - st_cyc[s0 % 32]), 32'd16);
        chk("to_resp_lat", 32'(resp_cyc - abort_cyc), 32'd1);
        chk("to_status", 32'(r_status), 32'd3);

        // bus_done in the very cycle the timeout would fire wins
        s0 = nstart; r0 = nresp; a0 = nabort;
        issue(24'h000400, 2'd1, 1'b1, 3'd1, 32'h0);
        reply(s0 + 1, 16, 16'h0BAD, 1'b0);
        wait_resp(r0 + 1);
        chk("race_nabort", 32'(nabort - a0), 32'd0);
        chk("race_status", 32'(r_status), 32'd0);
        chk("race_rdata", r_rdata, 32'h00000BAD);

        // Reset during the second half of a long write
        s0 = nstart; r0 = nresp;
        issue(24'h000300, 2'd2, 1'b0, 3'd1, 32'hCAFEF00D);
        reply(s0 + 1, 2, 16'h0, 1'b0);
        wait_start(s0 + 2);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("mrst_ready_in_rst", 32'(sif.req_ready), 32'd1);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mrst_nresp", 32'(nresp - r0), 32'd0);
        chk("mrst_ready", 32'(sif.req_ready), 32'd1);
        chk("mrst_rdata", sif.resp_rdata, 32'h0);
        chk("mrst_nstart", 32'(nstart - s0), 32'd2);

        // Normal request after the reset
        s0 = nstart; r0 = nresp;
        issue(24'h000010, 2'd1, 1'b1, 3'd2, 32'h0);
        reply(s0 + 1, 3, 16'h0F0F, 1'b0);
        wait_resp(r0 + 1);
        chk("post_addr", 32'(st_addr[s0 % 32]), 32'h000008);
        chk("post_status", 32'(r_status), 32'd0);
        chk("post_rdata", r_rdata, 32'h00000F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
